// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - duty-cycle ramp controller feeding a PWM generator's duty_i
// Define PWM_RAMP_RETRIGGER_EN to accept new requests while a ramp is in progress.
module pwm_ramp_ctrl #(
  parameter int WIDTH     = 8,
  parameter int IVL_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 req_i,
  input  logic [WIDTH-1:0]     target_i,
  input  logic [WIDTH-1:0]     step_i,
  input  logic [IVL_WIDTH-1:0] interval_i,
  output logic                 ack_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [WIDTH-1:0]     duty_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [WIDTH-1:0]     target_q;
  logic [WIDTH-1:0]     step_q;
  logic [WIDTH-1:0]     duty_q;
  logic [WIDTH-1:0]     duty_next;
  logic [IVL_WIDTH-1:0] ivl_q;
  logic [IVL_WIDTH-1:0] cnt_q;
  logic                 ack_q;
  logic                 accept;
  logic                 step_now;
  logic [WIDTH:0]       duty_x;
  logic [WIDTH:0]       target_x;
  logic [WIDTH:0]       step_x;
  logic [WIDTH:0]       sum_x;
  logic [WIDTH:0]       dif_x;

  always_comb begin
`ifdef PWM_RAMP_RETRIGGER_EN
    accept = req_i && ((state_q == S_IDLE) || (state_q == S_RAMP));
`else
    accept = req_i && (state_q == S_IDLE);
`endif
  end

  // A fresh acceptance restarts the interval, so it suppresses a coinciding step.
  assign step_now = (state_q == S_RAMP) && !accept && (cnt_q == ivl_q);

  // One extra bit keeps the carry/borrow visible, so duty clamps at target instead of wrapping.
  always_comb begin
    duty_x    = {1'b0, duty_q};
    target_x  = {1'b0, target_q};
    step_x    = (step_q == '0) ? (WIDTH+1)'(1) : {1'b0, step_q};
    sum_x     = duty_x + step_x;
    dif_x     = duty_x - step_x;
    duty_next = duty_q;
    if (target_x > duty_x) begin
      duty_next = (sum_x >= target_x) ? target_q : sum_x[WIDTH-1:0];
    end else if (target_x < duty_x) begin
      duty_next = (dif_x[WIDTH] || (dif_x <= target_x)) ? target_q : dif_x[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (target_i == duty_q) ? S_DONE : S_RAMP;
        end
      end
      S_RAMP: begin
`ifdef PWM_RAMP_RETRIGGER_EN
        if (accept) begin
          state_d = (target_i == duty_q) ? S_DONE : S_RAMP;
        end else if (step_now && (duty_next == target_q)) begin
          state_d = S_DONE;
        end
`else
        if (step_now && (duty_next == target_q)) begin
          state_d = S_DONE;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    ack_o  = ack_q;
    duty_o = duty_q;
    case (state_q)
      S_RAMP: busy_o = 1'b1;
      S_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= 1'b0;
      target_q <= '0;
      step_q   <= '0;
      ivl_q    <= '0;
      cnt_q    <= '0;
      duty_q   <= '0;
    end else begin
      ack_q <= accept;
      if (accept) begin
        target_q <= target_i;
        step_q   <= step_i;
        ivl_q    <= interval_i;
        cnt_q    <= '0;
      end else if (state_q == S_RAMP) begin
        if (step_now) begin
          cnt_q  <= '0;
          duty_q <= duty_next;
        end else begin
          cnt_q <= cnt_q + IVL_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the duty word width; it matches the driven PWM generator's duty_i width.
REQ-002 Parameter IVL_WIDTH, default 16, SHALL set the step-interval word width.
REQ-003 clk_i  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_i  input  1  SHALL request a new ramp; it is a level, sampled every cycle.
REQ-006 target_i  input  WIDTH  SHALL be the ramp end duty, latched on acceptance.
REQ-007 step_i  input  WIDTH  SHALL be the duty increment per step, latched on acceptance.
REQ-008 interval_i  input  IVL_WIDTH  SHALL set the cycles between steps minus one, latched on acceptance.
REQ-009 ack_o  output  1  SHALL be a one-cycle pulse marking request acceptance.
REQ-010 busy_o  output  1  SHALL be high whenever the state is not IDLE.
REQ-011 done_o  output  1  SHALL be a one-cycle pulse when duty_o reaches the latched target.
REQ-012 duty_o  output  WIDTH  SHALL be the registered duty word driving the PWM generator's duty_i.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RAMP and DONE.
REQ-014 Acceptance SHALL occur on an edge where the state is IDLE and req_i=1: latch target, step and interval; clear the interval counter; set ack_o=1 for the following cycle.
REQ-015 On acceptance, if the latched target equals duty_o, the next state SHALL be DONE; otherwise it SHALL be RAMP.
REQ-016 In RAMP, the interval counter SHALL increment each edge; on the edge where it equals the latched interval, it SHALL clear and duty_o SHALL take one step.
REQ-017 Steps SHALL occur every interval+1 edges; the first step SHALL occur interval+1 edges after the acceptance edge; interval=0 SHALL step every edge.
REQ-018 Step up (target>duty): if target-duty<=step then duty=target, else duty+step; step down mirrors this; duty SHALL never overshoot the target or wrap.
REQ-019 Step arithmetic SHALL use WIDTH+1 bits internally, so that no wrap-around occurs at 2^WIDTH-1 or 0.
REQ-020 A latched step of 0 SHALL be treated as 1.
REQ-021 On the step edge where the new duty equals the target, the next state SHALL be DONE.
REQ-022 DONE SHALL last one cycle with done_o=1 and then return to IDLE; a req_i in the DONE cycle SHALL be ignored.
REQ-023 duty_o SHALL hold its value in IDLE and DONE, and between steps.
REQ-024 Without PWM_RAMP_RETRIGGER_EN, req_i in RAMP SHALL be ignored (no ack_o, no latch).

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE, duty_o=0, ack_o=0, done_o=0, busy_o=0, interval counter=0, and latched target, step and interval to 0.
REQ-026 Reset asserted mid-ramp SHALL abandon the ramp with no done_o pulse.
REQ-027 After deassertion, the first acceptance SHALL be possible on the first rising edge.

Configuration
REQ-028 The macro PWM_RAMP_RETRIGGER_EN SHALL control retriggering.
REQ-029 When the macro is defined, req_i=1 in RAMP SHALL be accepted as in REQ-014: ack_o pulses, new parameters latch, the counter clears, and the ramp continues from the current duty_o. If the new target equals duty_o, the next state SHALL be DONE.
REQ-030 When the macro is undefined, REQ-024 SHALL apply and the retrigger logic SHALL be absent.

Verification
REQ-031 The bench SHALL cover: duty 0, target=25, step=10, interval=2, req on edge 1 -> ack cycle after edge 1; duty 10 @edge4, 20 @edge7, 25 @edge10; done_o after edge10; IDLE after edge11.
REQ-032 The bench SHALL cover: duty 200, target=5, step=100, interval=0 -> duty 100, then 5 on consecutive edges; no wrap; one done_o pulse.
REQ-033 The bench SHALL cover: target=duty=0 at acceptance -> ack_o and done_o in the same cycle; duty_o unchanged.
REQ-034 The bench SHALL cover: step=0, target=3, interval=0 from duty 0 -> duty 1, 2, 3 on consecutive edges.
REQ-035 The bench SHALL cover: rst_n pulsed low while duty=40 mid-ramp -> duty_o=0 and busy_o=0 immediately, with no done_o.
REQ-036 The bench SHALL cover: req with target=50 during a ramp to 200 -> without the macro, no ack_o and final duty 200; with the macro, ack_o and final duty 50.
